// File: rtl/lrrr_sequencer.sv
// Command-side controller for the Lrrr boss mover: entry delay, flight with
// periodic and forced dodges, hit handling with invulnerability, and death.
module lrrr_sequencer #(
   parameter int ENTRY_FRAMES  = 60,
   parameter int DODGE_PERIOD  = 45,
   parameter int INVULN_FRAMES = 30,
   parameter int MAX_HEALTH    = 5,
   parameter int Y_LIMIT       = 400
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        startOfFrame,
   input  logic        enable,
   input  logic        hit,
   input  logic [10:0] topLeftX,
   input  logic [10:0] topLeftY,
   output logic        waiting,
   output logic        toggleY,
   output logic [3:0]  health,
   output logic        flash,
   output logic        dead
);

   // state  | meaning
   // IDLE   | game not running, mover held at start position
   // ENTRY  | counting entry frames, mover still held
   // ACTIVE | flying, dodging, hits accepted
   // INVULN | flying after a hit, hits ignored, flash on
   // DEAD   | health exhausted, held until enable drops
   typedef enum logic [2:0] {IDLE, ENTRY, ACTIVE, INVULN, DEAD} stateType;

   localparam logic [7:0]  ENTRY_LAST  = 8'(ENTRY_FRAMES);
   localparam logic [7:0]  DODGE_LAST  = 8'(DODGE_PERIOD);
   localparam logic [7:0]  INVULN_LAST = 8'(INVULN_FRAMES);
   localparam logic [3:0]  HEALTH_INIT = 4'(MAX_HEALTH);
   localparam logic [10:0] Y_LIM       = 11'(Y_LIMIT);

   stateType    state, stateNxt;
   logic [7:0]  frameCnt, frameCntNxt;
   logic [7:0]  dodgeCnt, dodgeCntNxt;
   logic [7:0]  invulnCnt, invulnCntNxt;
   logic [2:0]  holdoff, holdoffNxt;
   logic        pending, pendingNxt;
   logic [3:0]  healthNxt;
   logic        waitingNxt, toggleNxt, flashNxt, deadNxt;
   logic        dodgeReq, flyingNxt;
   logic [7:0]  frameInc, dodgeInc, invulnInc;
   logic        unusedX;

   assign unusedX   = ^topLeftX;
   assign frameInc  = frameCnt + 8'd1;
   assign dodgeInc  = dodgeCnt + 8'd1;
   assign invulnInc = invulnCnt + 8'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         frameCnt  <= 8'd0;
         dodgeCnt  <= 8'd0;
         invulnCnt <= 8'd0;
         holdoff   <= 3'd0;
         pending   <= 1'b0;
         waiting   <= 1'b1;
         toggleY   <= 1'b0;
         health    <= 4'd0;
         flash     <= 1'b0;
         dead      <= 1'b0;
      end else begin
         state     <= stateNxt;
         frameCnt  <= frameCntNxt;
         dodgeCnt  <= dodgeCntNxt;
         invulnCnt <= invulnCntNxt;
         holdoff   <= holdoffNxt;
         pending   <= pendingNxt;
         waiting   <= waitingNxt;
         toggleY   <= toggleNxt;
         health    <= healthNxt;
         flash     <= flashNxt;
         dead      <= deadNxt;
      end
   end

   always_comb begin
      stateNxt     = state;
      frameCntNxt  = frameCnt;
      dodgeCntNxt  = dodgeCnt;
      invulnCntNxt = invulnCnt;
      holdoffNxt   = holdoff;
      healthNxt    = health;
      dodgeReq     = 1'b0;
      pendingNxt   = 1'b0;
      toggleNxt    = 1'b0;
      waitingNxt   = 1'b1;
      flashNxt     = 1'b0;
      deadNxt      = 1'b0;
      flyingNxt    = 1'b0;

      case (state)
         IDLE: begin
            if (enable) begin
               stateNxt    = ENTRY;
               healthNxt   = HEALTH_INIT;
               frameCntNxt = 8'd0;
            end
         end
         ENTRY: begin
            if (!enable) begin
               stateNxt = IDLE;
            end else if (startOfFrame) begin
               if (frameInc == ENTRY_LAST) begin
                  stateNxt     = ACTIVE;
                  frameCntNxt  = 8'd0;
                  dodgeCntNxt  = 8'd0;
                  invulnCntNxt = 8'd0;
                  holdoffNxt   = 3'd0;
               end else begin
                  frameCntNxt = frameInc;
               end
            end
         end
         ACTIVE, INVULN: begin
            if (!enable) begin
               stateNxt = IDLE;
            end else begin
               if (startOfFrame) begin
                  if (dodgeInc == DODGE_LAST) begin
                     dodgeCntNxt = 8'd0;
                     dodgeReq    = 1'b1;
                  end else begin
                     dodgeCntNxt = dodgeInc;
                  end
                  // holdoff reloads to 7 so the next forced dodge lands 8 frames later
                  if (holdoff != 3'd0) begin
                     holdoffNxt = holdoff - 3'd1;
                  end else if (topLeftY >= Y_LIM) begin
                     dodgeReq   = 1'b1;
                     holdoffNxt = 3'd7;
                  end
               end
               if (state == ACTIVE && hit) begin
                  if (health > 4'd1) begin
                     healthNxt    = health - 4'd1;
                     dodgeReq     = 1'b1;
                     stateNxt     = INVULN;
                     invulnCntNxt = 8'd0;
                  end else begin
                     healthNxt = 4'd0;
                     stateNxt  = DEAD;
                  end
               end else if (state == INVULN && startOfFrame) begin
                  if (invulnInc == INVULN_LAST) begin
                     stateNxt     = ACTIVE;
                     invulnCntNxt = 8'd0;
                  end else begin
                     invulnCntNxt = invulnInc;
                  end
               end
            end
         end
         DEAD: begin
            if (!enable) begin
               stateNxt = IDLE;
            end
         end
         default: stateNxt = IDLE;
      endcase

      flyingNxt = (stateNxt == ACTIVE) || (stateNxt == INVULN);
      if (flyingNxt) begin
         waitingNxt = 1'b0;
         flashNxt   = (stateNxt == INVULN);
         // a request landing while toggleY is high is held one cycle so the
         // mover always sees a low cycle between pulses
         toggleNxt  = (dodgeReq || pending) && !toggleY;
         pendingNxt = (dodgeReq || pending) && toggleY;
      end
      deadNxt = (stateNxt == DEAD);
   end

endmodule

// File: tb/tb_lrrr_sequencer.sv
// Randomized bench for lrrr_sequencer: frame-level reference model feeding a
// toggleY scoreboard, plus per-cycle checks of the level outputs.
module tb_lrrr_sequencer;
   localparam int ENTRY_FRAMES  = 60;
   localparam int DODGE_PERIOD  = 45;
   localparam int INVULN_FRAMES = 30;
   localparam int MAX_HEALTH    = 5;
   localparam int Y_LIMIT       = 400;

   logic        clk = 1'b0;
   logic        reset;
   logic        startOfFrame;
   logic        enable;
   logic        hit;
   logic [10:0] topLeftX;
   logic [10:0] topLeftY;
   logic        waiting;
   logic        toggleY;
   logic [3:0]  health;
   logic        flash;
   logic        dead;

   lrrr_sequencer dut (
      .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .enable(enable),
      .hit(hit), .topLeftX(topLeftX), .topLeftY(topLeftY), .waiting(waiting),
      .toggleY(toggleY), .health(health), .flash(flash), .dead(dead)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int edges  = 0;
   int expQ[$];
   int monExp;

   // reference model: game phase as plain flags and frame counts
   bit mRunning, mFlying, mDead, mInv;
   int mHp, mEntry, mFlight, mLastForced, mHitF;

   always @(posedge clk) edges = edges + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (edge %0d)", name, act, exp, edges);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && toggleY) begin
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("FAIL toggleY_unexpected actual=1 expected=0 (edge %0d)", edges);
         end else begin
            monExp = expQ.pop_front();
            if (monExp != edges) begin
               errors++;
               $display("FAIL toggleY_edge actual=%0d expected=%0d", edges, monExp);
            end
         end
      end
   end

   task automatic modelReset();
      mRunning = 0; mFlying = 0; mDead = 0; mInv = 0;
      mHp = 0; mEntry = 0; mFlight = 0; mLastForced = -100; mHitF = 0;
   endtask

   task automatic modelEdge(input bit sof, input bit h);
      bit dodge;
      dodge = 0;
      if (mDead) begin
         if (!enable) begin mDead = 0; mRunning = 0; end
      end else if (!mRunning) begin
         if (enable) begin mRunning = 1; mHp = MAX_HEALTH; mEntry = 0; mFlying = 0; end
      end else if (!enable) begin
         mRunning = 0; mFlying = 0; mInv = 0;
      end else if (!mFlying) begin
         if (sof) begin
            mEntry++;
            if (mEntry == ENTRY_FRAMES) begin
               mFlying = 1; mFlight = 0; mLastForced = -100; mInv = 0;
            end
         end
      end else begin
         if (sof) begin
            mFlight++;
            if (mFlight % DODGE_PERIOD == 0) dodge = 1;
            if (int'(topLeftY) >= Y_LIMIT && mFlight - mLastForced >= 8) begin
               dodge = 1;
               mLastForced = mFlight;
            end
         end
         if (h && !mInv) begin
            if (mHp > 1) begin
               mHp--; dodge = 1; mInv = 1; mHitF = mFlight;
            end else begin
               mHp = 0; mDead = 1; mFlying = 0; dodge = 0;
            end
         end else if (mInv && sof && mFlight - mHitF == INVULN_FRAMES) begin
            mInv = 0;
         end
         if (dodge) expQ.push_back(edges + 1);
      end
   endtask

   task automatic step(input bit sof, input bit h);
      startOfFrame = sof;
      hit = h;
      modelEdge(sof, h);
      @(negedge clk);
      chk("waiting", int'(waiting), int'(!mFlying));
      chk("flash", int'(flash), int'(mFlying && mInv));
      chk("health", int'(health), mHp);
      chk("dead", int'(dead), int'(mDead));
      startOfFrame = 1'b0;
      hit = 1'b0;
   endtask

   task automatic frame(input bit hitSof, input bit hitGap);
      step(1'b1, hitSof);
      step(1'b0, 1'b0);
      step(1'b0, hitGap);
      repeat ($urandom_range(1, 4)) step(1'b0, 1'b0);
   endtask

   function automatic logic [10:0] pickY();
      case ($urandom_range(0, 4))
         0: return 11'd100;
         1: return 11'd399;
         2: return 11'd400;
         3: return 11'd420;
         default: return 11'(1000 + $urandom_range(0, 900));
      endcase
   endfunction

   int guard;

   initial begin
      reset = 1'b1; enable = 1'b0; startOfFrame = 1'b0; hit = 1'b0;
      topLeftX = 11'd320; topLeftY = 11'd100;
      modelReset();
      repeat (3) @(negedge clk);
      chk("rst_waiting", int'(waiting), 1);
      chk("rst_toggleY", int'(toggleY), 0);
      chk("rst_health", int'(health), 0);
      chk("rst_flash", int'(flash), 0);
      chk("rst_dead", int'(dead), 0);
      reset = 1'b0;
      repeat (2) step(1'b0, 1'b0);

      // entry: hits during entry are ignored
      enable = 1'b1;
      step(1'b0, 1'b0);
      repeat (ENTRY_FRAMES - 1) frame(1'b0, $urandom_range(0, 3) == 0);
      chk("entry_waiting_before_last", int'(waiting), 1);
      step(1'b1, 1'b0);
      chk("entry_waiting_after_last", int'(waiting), 0);
      chk("entry_health", int'(health), MAX_HEALTH);
      repeat (3) step(1'b0, 1'b0);

      // periodic dodges, then forced run starting on a periodic frame (135)
      repeat (134) begin
         topLeftX = 11'($urandom_range(0, 1500));
         frame(1'b0, 1'b0);
      end
      topLeftY = 11'd420;
      repeat (16) frame(1'b0, 1'b0);
      topLeftY = 11'd100;

      // hits 5 frames apart: only the first counts
      frame(1'b0, 1'b1);
      repeat (4) frame(1'b0, 1'b0);
      frame(1'b0, 1'b1);
      repeat (4) frame(1'b0, 1'b0);
      frame(1'b0, 1'b1);
      chk("hit_health4", int'(health), 4);
      chk("hit_flash_on", int'(flash), 1);
      repeat (30) frame(1'b0, 1'b0);
      chk("hit_flash_off", int'(flash), 0);
      frame(1'b0, 1'b1);
      chk("hit_health3", int'(health), 3);

      // random flight
      for (int i = 0; i < 120; i++) begin
         if (i % 6 == 0) topLeftY = pickY();
         frame($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
      end

      // hit until dead
      guard = 0;
      while (!mDead && guard < 500) begin
         if (guard % 5 == 0) topLeftY = pickY();
         frame(1'b0, 1'b1);
         guard++;
      end
      chk("dead_flag", int'(dead), 1);
      chk("dead_waiting", int'(waiting), 1);
      chk("dead_health", int'(health), 0);
      repeat (3) frame(1'b0, 1'b1);
      enable = 1'b0;
      step(1'b0, 1'b0);
      chk("dead_cleared", int'(dead), 0);
      repeat (2) step(1'b0, 1'b0);

      // enable drop during invulnerability keeps health
      enable = 1'b1;
      topLeftY = 11'd100;
      step(1'b0, 1'b0);
      repeat (ENTRY_FRAMES) frame(1'b0, 1'b0);
      repeat (5) frame(1'b0, 1'b0);
      frame(1'b0, 1'b1);
      repeat (3) frame(1'b0, 1'b0);
      enable = 1'b0;
      step(1'b0, 1'b0);
      chk("drop_health", int'(health), 4);
      chk("drop_flash", int'(flash), 0);
      chk("drop_waiting", int'(waiting), 1);
      step(1'b1, 1'b1);
      enable = 1'b1;
      step(1'b0, 1'b0);
      chk("reenable_health", int'(health), MAX_HEALTH);

      // reach INVULN with health 2, then asynchronous reset
      repeat (ENTRY_FRAMES) frame(1'b0, 1'b0);
      repeat (2) frame(1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         frame(1'b0, 1'b1);
         if (k < 2) begin
            repeat (31) begin
               topLeftY = pickY();
               frame(1'b0, 1'b0);
            end
         end
      end
      topLeftY = 11'd100;
      repeat (3) frame(1'b0, 1'b0);
      chk("pre_reset_health", int'(health), 2);
      chk("pre_reset_flash", int'(flash), 1);
      chk("pending_toggles", expQ.size(), 0);
      #2;
      reset = 1'b1;
      #1;
      chk("async_waiting", int'(waiting), 1);
      chk("async_flash", int'(flash), 0);
      chk("async_health", int'(health), 0);
      chk("async_toggleY", int'(toggleY), 0);
      chk("async_dead", int'(dead), 0);
      modelReset();
      expQ.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      enable = 1'b0;
      repeat (2) step(1'b0, 1'b0);
      enable = 1'b1;
      step(1'b0, 1'b0);
      repeat (4) frame(1'b0, 1'b1);
      chk("final_pending_toggles", expQ.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
